// File: rtl/program_sequencer.sv
// Program sequencer: PC/INC/J1/J2/INST registers, address-bus source mux,
// return-address stack for call/return and a three-state instruction fetcher.
module program_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_oe,
    input  logic              sel_pc,
    input  logic              sel_inc,
    input  logic              sel_j,
    input  logic              ld_j1,
    input  logic              ld_j2,
    input  logic              ld_inst,
    input  logic              ld_inc,
    input  logic              ld_pc,
    input  logic              push_ret,
    input  logic              pop_ret,
    input  logic              fetch_start,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] j,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int MEM_N = 1 << SP_W;
    localparam logic [SP_W-1:0]   SP_MAX   = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_ADV  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] inc_q;
    logic [DATA_W-1:0] j1;
    logic [DATA_W-1:0] j2;
    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] stack_mem [0:MEM_N-1];
    logic [ADDR_W-1:0] stack_top;

    logic idle;
    logic push_req;
    logic pop_req;
    logic do_push;
    logic do_pop;
    logic do_swap;
    logic err_set;

    // External controls only count while the fetcher is parked in IDLE
    assign idle      = (state == S_IDLE);
    assign push_req  = idle & push_ret;
    assign pop_req   = idle & pop_ret;
    assign stack_top = stack_mem[sp - SP_ONE];

    assign do_pop  = pop_req & ~stack_empty;
    assign do_swap = pop_req & push_req & ~stack_empty;
    assign do_push = push_req & ~pop_req & ~stack_full;
    assign err_set = (pop_req & stack_empty) | (push_req & ~pop_req & stack_full);

    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_MAX);
    assign fetch_busy  = ~idle;
    assign fetch_done  = (state == S_ADV);
    assign j           = {j1, j2};

    always_comb begin
        addr_out = '0;
        addr_oe  = 1'b0;
        case (state)
            S_ADDR, S_DATA: begin
                addr_out = pc;
                addr_oe  = 1'b1;
            end
            S_ADV: begin
                addr_out = inc_q;
                addr_oe  = 1'b1;
            end
            default: begin
                addr_oe = sel_pc | sel_inc | sel_j;
                if (sel_pc)
                    addr_out = pc;
                else if (sel_inc)
                    addr_out = inc_q;
                else if (sel_j)
                    addr_out = {j1, j2};
            end
        endcase
    end

    // Stack storage needs no reset: sp decides which entries are live
    always_ff @(posedge clock) begin
        if (do_push)
            stack_mem[sp] <= inc_q;
        else if (do_swap)
            stack_mem[sp - SP_ONE] <= inc_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            inc_q     <= '0;
            j1        <= '0;
            j2        <= '0;
            inst      <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_start)
                        state <= S_ADDR;
                    if (ld_j1)
                        j1 <= data_in;
                    if (ld_j2)
                        j2 <= data_in;
                    if (ld_inst)
                        inst <= data_in;
                    if (ld_inc)
                        inc_q <= addr_in + ADDR_ONE;
                    // ld_inc suppresses ld_pc even though it does not write PC itself
                    if (do_pop)
                        pc <= stack_top;
                    else if (ld_pc && !ld_inc)
                        pc <= addr_in;
                    if (do_push)
                        sp <= sp + SP_ONE;
                    else if (do_pop && !push_req)
                        sp <= sp - SP_ONE;
                    if (err_set)
                        stack_err <= 1'b1;
                end
                S_ADDR: begin
                    inc_q <= pc + ADDR_ONE;
                    state <= S_DATA;
                end
                S_DATA: begin
                    inst  <= data_in;
                    state <= S_ADV;
                end
                S_ADV: begin
                    pc    <= inc_q;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
